// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg: shared FSM state encoding and default node-record constants
package dijkstra_pkg;

    typedef enum logic [1:0] {IDLE, OPEN, EMIT_ADDR, EMIT_LEN} state_t;

    localparam int DEF_VISIT_VALUE  = 1;
    localparam int DEF_FIELD_OFFSET = 3;
    localparam int DEF_NODE_STRIDE  = 16;

endpackage

// File: rtl/burst_idle_timer.sv
// burst_idle_timer: counts idle cycles of an open burst and flags the one that reaches TIMEOUT
module burst_idle_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // expired fires in the idle cycle whose increment would bring the count to TIMEOUT
    assign expired = enable && cnt == LAST;

    // idle-cycle counter, restarted on every accepted word and outside an open burst
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/write_node_field_burst.sv
// write_node_field_burst: coalesces field writes to consecutive node records into bursts plus (base,len) descriptors
module write_node_field_burst
    import dijkstra_pkg::*;
#(
    parameter int W_D          = 32,
    parameter int FIELD_OFFSET = DEF_FIELD_OFFSET,
    parameter int NODE_STRIDE  = DEF_NODE_STRIDE,
    parameter int MAX_BURST    = 16,
    parameter int TIMEOUT      = 64,
    parameter int VALUE_MODE   = 0,
    parameter int VISIT_VALUE  = DEF_VISIT_VALUE
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [W_D-1:0] write_addr,
    input  logic [W_D-1:0] write_data,
    input  logic           write_valid,
    output logic           write_ready,
    input  logic           flush,
    output logic [W_D-1:0] stream_d,
    output logic           stream_enq,
    input  logic           stream_almost_full,
    output logic [W_D-1:0] comm_d,
    output logic           comm_enq,
    input  logic           comm_almost_full,
    output logic           idle
);

    localparam int LW = $clog2(MAX_BURST + 1);
    localparam logic [W_D-1:0] OFFSET_B = W_D'(FIELD_OFFSET * (W_D / 8));
    localparam logic [W_D-1:0] STRIDE   = W_D'(NODE_STRIDE);
    localparam logic [LW-1:0]  LAST     = LW'(MAX_BURST);

    state_t         state, state_nx;
    logic [W_D-1:0] base, prev;
    logic [LW-1:0]  len;
    logic           in_open, in_emit, consec, xfer, expired;

    assign in_open     = state == OPEN;
    assign in_emit     = state == EMIT_ADDR || state == EMIT_LEN;
    assign idle        = state == IDLE;
    assign consec      = write_addr == prev + STRIDE;
    assign write_ready = !stream_almost_full && (idle || (in_open && consec));
    assign xfer        = write_valid && write_ready;
    assign stream_enq  = xfer && RST;
    assign stream_d    = (VALUE_MODE != 0) ? write_data : W_D'(VISIT_VALUE);
    assign comm_enq    = in_emit && !comm_almost_full;
    assign comm_d      = state == EMIT_ADDR ? base : state == EMIT_LEN ? W_D'(len) : '0;

    burst_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (!in_open || xfer),
        .enable  (in_open && !xfer),
        .expired (expired)
    );

    // next state: a burst closes on full length, flush, a non-consecutive request or idle timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (xfer) state_nx = (LAST == LW'(1)) ? EMIT_ADDR : OPEN;
            OPEN:      if ((xfer && len + 1'b1 == LAST) || flush || (write_valid && !consec) || expired)
                           state_nx = EMIT_ADDR;
            EMIT_ADDR: if (comm_enq) state_nx = EMIT_LEN;
            EMIT_LEN:  if (comm_enq) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // state register and burst bookkeeping; the first word of a burst fixes its base
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            base  <= '0;
            prev  <= '0;
            len   <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                prev <= write_addr;
                if (idle) begin
                    base <= write_addr + OFFSET_B;
                    len  <= LW'(1);
                end else begin
                    len <= len + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_node_field_burst.sv
// tb_write_node_field_burst: directed and randomized checks of burst coalescing against a transaction-level model
module tb_write_node_field_burst;

    localparam int MB = 16;

    logic        CLK, RST, flush, write_valid, stream_almost_full, comm_almost_full;
    logic [31:0] write_addr, write_data;
    logic        write_ready, stream_enq, comm_enq, idle;
    logic [31:0] stream_d, comm_d;
    logic        write_ready_1, stream_enq_1, comm_enq_1, idle_1;
    logic [31:0] stream_d_1, comm_d_1;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] sq[$], sq1[$], cq[$], dq[$];
    int csn[$];
    int sp = 0, cp = 0;
    logic [31:0] a0, d;
    int k, w, gap, n, rem;

    write_node_field_burst u0 (
        .CLK(CLK), .RST(RST), .write_addr(write_addr), .write_data(write_data),
        .write_valid(write_valid), .write_ready(write_ready), .flush(flush),
        .stream_d(stream_d), .stream_enq(stream_enq), .stream_almost_full(stream_almost_full),
        .comm_d(comm_d), .comm_enq(comm_enq), .comm_almost_full(comm_almost_full), .idle(idle)
    );

    write_node_field_burst #(.VALUE_MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .write_addr(write_addr), .write_data(write_data),
        .write_valid(write_valid), .write_ready(write_ready_1), .flush(flush),
        .stream_d(stream_d_1), .stream_enq(stream_enq_1), .stream_almost_full(stream_almost_full),
        .comm_d(comm_d_1), .comm_enq(comm_enq_1), .comm_almost_full(comm_almost_full), .idle(idle_1)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // capture everything the DUTs enqueue, with the stream depth seen at each descriptor word
    always @(negedge CLK) begin
        if (RST) begin
            if (comm_enq) begin
                cq.push_back(comm_d);
                csn.push_back(sq.size());
            end
            if (stream_enq) sq.push_back(stream_d);
            if (stream_enq_1) sq1.push_back(stream_d_1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] dat, output int waited);
        write_addr  = a;
        write_data  = dat;
        write_valid = 1;
        waited      = 0;
        @(negedge CLK);
        while (!write_ready && waited < 300) begin
            waited++;
            @(negedge CLK);
        end
        chk("accept", 32'(write_ready), 32'd1);
        @(posedge CLK); #1;
        write_valid = 0;
    endtask

    task automatic exp_desc(input string tag, input logic [31:0] b, input logic [31:0] l, input int sc);
        int t = 0;
        while (cq.size() < cp + 2 && t < 400) begin
            @(negedge CLK);
            t++;
        end
        if (cq.size() < cp + 2) begin
            chk({tag, "_timeout"}, 32'(cq.size()), 32'(cp + 2));
        end else begin
            chk({tag, "_base"}, cq[cp], b);
            chk({tag, "_len"}, cq[cp + 1], l);
            chk({tag, "_order"}, 32'(csn[cp]), 32'(sc));
            cp += 2;
        end
        @(posedge CLK); #1;
    endtask

    task automatic take_words(input string tag, input int cnt);
        chk({tag, "_count"}, 32'(sq.size() - sp), 32'(cnt));
        for (int i = 0; i < cnt && sp + i < sq.size(); i++)
            chk({tag, "_visit"}, sq[sp + i], 32'd1);
        sp = sq.size();
    endtask

    task automatic pulse_flush();
        flush = 1;
        @(posedge CLK); #1;
        flush = 0;
    endtask

    initial begin
        RST = 0; flush = 0; write_valid = 0; stream_almost_full = 0; comm_almost_full = 0;
        write_addr = 0; write_data = 0;
        // reset state, including a request presented while reset is held
        repeat (2) @(posedge CLK);
        #1;
        write_valid = 1; write_addr = 32'h700;
        @(negedge CLK);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_stream_enq", 32'(stream_enq), 32'd0);
        chk("rst_stream_enq_1", 32'(stream_enq_1), 32'd0);
        chk("rst_comm_enq", 32'(comm_enq), 32'd0);
        chk("rst_comm_d", comm_d, 32'd0);
        chk("rst_ready", 32'(write_ready), 32'd1);
        stream_almost_full = 1;
        #1;
        chk("rst_ready_af", 32'(write_ready), 32'd0);
        stream_almost_full = 0; write_valid = 0;
        @(posedge CLK); #1;
        RST = 1;
        @(negedge CLK);
        chk("post_rst_idle", 32'(idle), 32'd1);
        @(posedge CLK); #1;

        // three consecutive writes then idle: descriptor after 64 idle cycles
        put(32'h100, 0, w); put(32'h110, 0, w); put(32'h120, 0, w);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!comm_enq && n < 300);
        chk("timeout_latency", 32'(n), 32'd65);
        chk("timeout_base_now", comm_d, 32'h10C);
        @(posedge CLK); #1;
        exp_desc("a", 32'h10C, 3, sp + 3);
        take_words("a", 3);

        // 20 consecutive writes: full burst of 16 then a timed-out burst of 4
        for (int i = 0; i < 20; i++) put(32'(16 * i), 0, w);
        exp_desc("b0", 32'h00C, 16, sp + 16);
        exp_desc("b1", 32'h10C, 4, sp + 20);
        take_words("b", 20);

        // non-consecutive address stalls for the two descriptor cycles
        put(32'h100, 0, w);
        put(32'h200, 0, w);
        chk("nonconsec_stall", 32'(w), 32'd3);
        exp_desc("c0", 32'h10C, 1, sp + 1);
        exp_desc("c1", 32'h20C, 1, sp + 2);
        take_words("c", 2);

        // descriptor channel back-pressure holds EMIT_ADDR
        comm_almost_full = 1;
        put(32'h400, 0, w);
        pulse_flush();
        write_valid = 1; write_addr = 32'h410;
        repeat (10) begin
            @(negedge CLK);
            chk("bp_comm_enq", 32'(comm_enq), 32'd0);
            chk("bp_ready", 32'(write_ready), 32'd0);
            chk("bp_idle", 32'(idle), 32'd0);
        end
        @(posedge CLK); #1;
        write_valid = 0; comm_almost_full = 0;
        @(negedge CLK);
        chk("bp_addr_enq", 32'(comm_enq), 32'd1);
        chk("bp_addr", comm_d, 32'h40C);
        @(negedge CLK);
        chk("bp_len_enq", 32'(comm_enq), 32'd1);
        chk("bp_len", comm_d, 32'd1);
        @(negedge CLK);
        chk("bp_back_idle", 32'(idle), 32'd1);
        @(posedge CLK); #1;
        cp += 2;
        take_words("d", 1);

        // flush while idle changes nothing
        pulse_flush();
        @(negedge CLK);
        chk("flush_idle", 32'(idle), 32'd1);
        chk("flush_idle_nodesc", 32'(cq.size()), 32'(cp));
        @(posedge CLK); #1;

        // flush together with a consecutive write, data mode checked on u1
        put(32'h100, 32'h44, w);
        write_valid = 1; write_addr = 32'h110; write_data = 32'h55; flush = 1;
        @(negedge CLK);
        chk("flush_wr_ready", 32'(write_ready), 32'd1);
        chk("flush_wr_data", stream_d_1, 32'h55);
        @(posedge CLK); #1;
        write_valid = 0; flush = 0;
        exp_desc("e", 32'h10C, 2, sp + 2);
        chk("e_data0", sq1[sp], 32'h44);
        chk("e_data1", sq1[sp + 1], 32'h55);
        take_words("e", 2);

        // reset mid-burst discards the burst; the next write opens afresh
        put(32'h500, 0, w); put(32'h510, 0, w);
        RST = 0;
        @(negedge CLK);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_comm_enq", 32'(comm_enq), 32'd0);
        @(posedge CLK); #1;
        RST = 1;
        repeat (80) @(negedge CLK);
        chk("mid_rst_nodesc", 32'(cq.size()), 32'(cp));
        @(posedge CLK); #1;
        put(32'h300, 0, w);
        pulse_flush();
        exp_desc("f", 32'h30C, 1, sp + 3);
        take_words("f", 3);

        // randomized consecutive runs, first one wrapping past the top address
        for (int r = 0; r < 6; r++) begin
            a0 = (r == 0) ? 32'hFFFF_FF80 : $urandom;
            k = $urandom_range(1, 40);
            dq.delete();
            for (int i = 0; i < k; i++) begin
                d = $urandom;
                dq.push_back(d);
                gap = $urandom_range(0, 3);
                repeat (gap) begin
                    @(posedge CLK); #1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    stream_almost_full = 1; write_valid = 1; write_addr = a0 + 32'(16 * i); write_data = d;
                    @(negedge CLK);
                    chk("rnd_af_enq", 32'(stream_enq), 32'd0);
                    chk("rnd_af_ready", 32'(write_ready), 32'd0);
                    @(posedge CLK); #1;
                    stream_almost_full = 0;
                end
                put(a0 + 32'(16 * i), d, w);
            end
            for (int j = 0; j * MB < k; j++) begin
                rem = k - j * MB;
                exp_desc("rnd", a0 + 32'(256 * j) + 32'd12, 32'((rem > MB) ? MB : rem),
                         sp + j * MB + ((rem > MB) ? MB : rem));
            end
            for (int i = 0; i < k && sp + i < sq1.size(); i++)
                chk("rnd_data", sq1[sp + i], dq[i]);
            take_words("rnd", k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/write_node_field_burst.md
WRITE_NODE_FIELD_BURST -- requirements
Module: write_node_field_burst

Interface
REQ-001 SHALL have parameter W_D, default 32: data and address word width.
REQ-002 SHALL have parameter FIELD_OFFSET, default 3: field word offset inside a node record. Byte offset = FIELD_OFFSET*(W_D/8).
REQ-003 SHALL have parameter NODE_STRIDE, default 16: byte distance between consecutive node records.
REQ-004 SHALL have parameter MAX_BURST, default 16: maximum number of words per burst, 1..255.
REQ-005 SHALL have parameter TIMEOUT, default 64: idle cycles that close an open burst, >=1.
REQ-006 SHALL have parameter VALUE_MODE, default 0: 0 writes constant VISIT_VALUE; 1 writes write_data.
REQ-007 SHALL have parameter VISIT_VALUE, default 1: constant written when VALUE_MODE=0.
REQ-008 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-009 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports write_addr/write_data, input, W_D each: node base byte address and value.
REQ-011 SHALL have ports write_valid in, 1 bit, and write_ready out, 1 bit: upstream handshake. Transfer when both are 1.
REQ-012 SHALL have port flush, input, 1 bit: request to close the open burst.
REQ-013 SHALL have ports stream_d out (W_D), stream_enq out (1), stream_almost_full in (1): data out-stream.
REQ-014 SHALL have ports comm_d out (W_D), comm_enq out (1), comm_almost_full in (1): descriptor channel to the control thread.
REQ-015 SHALL have port idle, output, 1 bit: high when FSM is IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, OPEN, EMIT_ADDR, EMIT_LEN.
REQ-017 IDLE: write_ready SHALL equal !stream_almost_full.
REQ-018 IDLE: on a transfer, SHALL latch base=write_addr+FIELD_OFFSET*(W_D/8), prev=write_addr, len=1, and go to OPEN.
REQ-019 OPEN: write_ready SHALL equal !stream_almost_full && (write_addr==prev+NODE_STRIDE). Ready is combinationally dependent on write_addr.
REQ-020 OPEN: on a transfer, SHALL set prev=write_addr, increment len, and clear the timeout counter.
REQ-021 OPEN: when write_valid=1 with a non-consecutive address, SHALL hold write_ready=0 and go to EMIT_ADDR next cycle. The pending write is accepted after the burst returns to IDLE.
REQ-022 OPEN: an accept that makes len==MAX_BURST SHALL go to EMIT_ADDR next cycle.
REQ-023 OPEN: each cycle without a transfer SHALL increment the timeout counter. At TIMEOUT, SHALL go to EMIT_ADDR.
REQ-024 OPEN: flush=1 SHALL go to EMIT_ADDR. A consecutive write in the same cycle SHALL still be accepted and counted in len.
REQ-025 IDLE, EMIT_ADDR and EMIT_LEN: flush SHALL be ignored.
REQ-026 Every transfer SHALL drive stream_enq=1 in the same cycle, combinationally. stream_d = VISIT_VALUE (mode 0) or write_data (mode 1). Latency 0, no buffering.
REQ-027 EMIT_ADDR: SHALL drive comm_d=base and comm_enq=!comm_almost_full, and advance to EMIT_LEN only when comm_enq=1.
REQ-028 EMIT_LEN: SHALL drive comm_d=len zero-extended to W_D and comm_enq=!comm_almost_full, and advance to IDLE only when comm_enq=1.
REQ-029 EMIT_ADDR and EMIT_LEN: write_ready SHALL be 0.
REQ-030 All data words of a burst SHALL be enqueued before its descriptor. Descriptor order SHALL equal burst order.
REQ-031 Address arithmetic SHALL be modulo 2^W_D. Wrap from the top address SHALL count as consecutive.
REQ-032 len SHALL be held in ceil(log2(MAX_BURST+1)) bits. The timeout counter SHALL be held in ceil(log2(TIMEOUT+1)) bits.

Reset
REQ-033 RST low SHALL asynchronously force state=IDLE and clear base, prev, len and the timeout counter.
REQ-034 During reset SHALL hold stream_enq=0, comm_enq=0, comm_d=0 and idle=1. write_ready follows REQ-017.
REQ-035 Reset mid-burst SHALL discard the open burst with no descriptor. Data words already enqueued stay in the stream.

Structure
REQ-036 State encoding and default VISIT_VALUE/FIELD_OFFSET/NODE_STRIDE constants SHALL live in the shared dijkstra_pkg package.
REQ-037 The timeout counter SHALL be the single sub-module, burst_idle_timer (inputs clear and enable; output expired).

Verification
REQ-038 Default parameters; writes 0x100, 0x110, 0x120 back-to-back, then none -> stream gets 3 words of 1; 64 idle cycles later comm gets 0x10C then 3.
REQ-039 20 consecutive writes from 0x000 -> descriptor (0x00C,16) right after the 16th; (0x10C,4) after timeout; 20 stream words.
REQ-040 Writes 0x100 then 0x200 -> write_ready low for 3 cycles on 0x200; descriptor (0x10C,1); later (0x20C,1).
REQ-041 comm_almost_full held high 10 cycles in EMIT_ADDR -> comm_enq=0, write_ready=0, state held; on release, (base,len) emitted in 2 cycles.
REQ-042 VALUE_MODE=1; flush together with consecutive write 0x110 (data 0x55) after 0x100 (data 0x44) -> stream 0x44, 0x55; descriptor (0x10C,2).
REQ-043 RST low after 2 accepted writes -> idle=1, no descriptor. The next write 0x300 opens a new burst with base 0x30C.
